// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin synchroniser and stable-count debounce filter with bus registers; GPIO_DEBOUNCE_IRQ_EN adds sticky CHG flags and IRQ
module gpio_debounce #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int GPIO_W  = 8,
  parameter int CNT_W   = 16,
  parameter int THR_RST = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              WE,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  input  logic [GPIO_W-1:0] PIN_IN,
  output logic [GPIO_W-1:0] GPI_OUT,
  output logic              IRQ
);
  localparam logic [ADDR_W-1:0] A_THR = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_BYP = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_STA = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_CHG = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_RAW = ADDR_W'(32'h10);
  logic [GPIO_W-1:0] s1, s2, flt, byp, upd, ev, chg;
  logic [CNT_W-1:0]  thr;
  logic [CNT_W-1:0]  cnt    [GPIO_W];
  logic [CNT_W-1:0]  cnt_nx [GPIO_W];
  logic [CNT_W:0]    thr_eff, inc;
  logic              unused_wd;
  assign unused_wd = ^WD;
  assign thr_eff = (thr == '0) ? (CNT_W+1)'(1) : {1'b0, thr};
  assign GPI_OUT = flt;
  // two-flop synchroniser on the raw pads
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= PIN_IN;
      s2 <= s1;
    end
  // per-pin filter decision: load flt when bypassed, settled, or the count reaches the threshold
  always_comb begin
    inc = '0;
    upd = '0;
    for (int k = 0; k < GPIO_W; k++) begin
      inc       = {1'b0, cnt[k]} + 1'b1;
      upd[k]    = byp[k] | (s2[k] == flt[k]) | (inc >= thr_eff);
      cnt_nx[k] = upd[k] ? '0 : inc[CNT_W-1:0];
    end
    ev = upd & (s2 ^ flt);
  end
  // filtered state and stable counters
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      flt <= '0;
      for (int k = 0; k < GPIO_W; k++) cnt[k] <= '0;
    end else begin
      flt <= (s2 & upd) | (flt & ~upd);
      for (int k = 0; k < GPIO_W; k++) cnt[k] <= cnt_nx[k];
    end
  // threshold and bypass configuration registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      thr <= CNT_W'(THR_RST);
      byp <= '0;
    end else if (WE) begin
      if (ADDR == A_THR) thr <= WD[CNT_W-1:0];
      if (ADDR == A_BYP) byp <= WD[GPIO_W-1:0];
    end
`ifdef GPIO_DEBOUNCE_IRQ_EN
  // sticky change flags, a new event wins over a same-cycle clear
  always_ff @(posedge CLK or posedge RST)
    if (RST) chg <= '0;
    else     chg <= (chg & ~((WE && ADDR == A_CHG) ? WD[GPIO_W-1:0] : '0)) | ev;
  assign IRQ = |chg;
`else
  logic unused_ev;
  assign unused_ev = ^ev;
  assign chg = '0;
  assign IRQ = 1'b0;
`endif
  // combinational read mux, unmapped addresses read zero
  always_comb
    RD = (ADDR == A_THR) ? DATA_W'(thr) :
         (ADDR == A_BYP) ? DATA_W'(byp) :
         (ADDR == A_STA) ? DATA_W'(flt) :
         (ADDR == A_CHG) ? DATA_W'(chg) :
         (ADDR == A_RAW) ? DATA_W'(s2)  : '0;
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed self-checking bench for gpio_debounce
module tb_gpio_debounce;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [7:0]  pin = '0;
  logic [7:0]  gpo;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] d;
`ifdef GPIO_DEBOUNCE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  gpio_debounce dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .WE(we), .WD(wd), .RD(rd),
    .PIN_IN(pin), .GPI_OUT(gpo), .IRQ(irq)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addr = a;
    wd = v;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask
  task automatic rdr(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask
  task automatic test_reset;
    step(2);
    rst = 1'b0;
    step(1);
    wr(32'h00, 32'd7);
    wr(32'h04, 32'h0F);
    pin = 8'hFF;
    step(5);
    checks++;
    if (gpo !== 8'h0F) begin errors++; $display("FAIL pre_reset_gpo got %h want 0f", gpo); end
    #3 rst = 1'b1;
    pin = 8'h00;
    #1;
    checks++;
    if (gpo !== 8'h00) begin errors++; $display("FAIL reset_gpo got %h want 00", gpo); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    rdr(32'h00, d); checks++;
    if (d !== 32'd16) begin errors++; $display("FAIL reset_thr got %0d want 16", d); end
    rdr(32'h04, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_bypass got %h want 0", d); end
    rdr(32'h08, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_state got %h want 0", d); end
    rdr(32'h0C, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_chg got %h want 0", d); end
    rdr(32'h10, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_raw got %h want 0", d); end
    rdr(32'h14, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
    step(1);
    rst = 1'b0;
    step(1);
  endtask
  task automatic test_clean_edge;
    wr(32'h00, 32'd4);
    pin[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      checks++;
      if (gpo[0] !== (k >= 6)) begin errors++; $display("FAIL clean_edge edge=%0d got %b want %b", k, gpo[0], k >= 6); end
      if (k == 2) begin
        rdr(32'h10, d); checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL clean_raw got %h want 1", d); end
      end
    end
    checks++;
    if (irq !== IRQ_ON) begin errors++; $display("FAIL clean_irq got %b want %b", irq, IRQ_ON); end
    rdr(32'h0C, d); checks++;
    if (d !== (IRQ_ON ? 32'h1 : 32'h0)) begin errors++; $display("FAIL clean_chg got %h want %h", d, IRQ_ON ? 32'h1 : 32'h0); end
    rdr(32'h08, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL clean_state got %h want 1", d); end
    wr(32'h0C, 32'h1);
    rdr(32'h0C, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clean_chg_clr got %h want 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL clean_irq_clr got %b want 0", irq); end
    pin[0] = 1'b0;
    step(5);
    checks++;
    if (gpo[0] !== 1'b1) begin errors++; $display("FAIL fall_early got %b want 1", gpo[0]); end
    step(1);
    checks++;
    if (gpo[0] !== 1'b0) begin errors++; $display("FAIL fall_edge got %b want 0", gpo[0]); end
    wr(32'h0C, 32'hFF);
  endtask
  task automatic test_glitch;
    logic seen = 1'b0;
    pin[3] = 1'b1;
    step(3);
    pin[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      seen |= gpo[3];
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_3cyc got %b want 0", seen); end
    rdr(32'h0C, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_chg got %h want 0", d); end
    pin[3] = 1'b1;
    step(4);
    pin[3] = 1'b0;
    step(1);
    checks++;
    if (gpo[3] !== 1'b0) begin errors++; $display("FAIL pulse4_early got %b want 0", gpo[3]); end
    step(1);
    checks++;
    if (gpo[3] !== 1'b1) begin errors++; $display("FAIL pulse4_pass got %b want 1", gpo[3]); end
    rdr(32'h0C, d); checks++;
    if (d !== (IRQ_ON ? 32'h8 : 32'h0)) begin errors++; $display("FAIL pulse4_chg got %h want %h", d, IRQ_ON ? 32'h8 : 32'h0); end
    step(3);
    checks++;
    if (gpo[3] !== 1'b1) begin errors++; $display("FAIL pulse4_hold got %b want 1", gpo[3]); end
    step(1);
    checks++;
    if (gpo[3] !== 1'b0) begin errors++; $display("FAIL pulse4_fall got %b want 0", gpo[3]); end
    wr(32'h0C, 32'hFF);
  endtask
  task automatic test_thr0_bypass;
    wr(32'h00, 32'd0);
    pin[1] = 1'b1;
    step(2);
    checks++;
    if (gpo[1] !== 1'b0) begin errors++; $display("FAIL thr0_early got %b want 0", gpo[1]); end
    step(1);
    checks++;
    if (gpo[1] !== 1'b1) begin errors++; $display("FAIL thr0_edge got %b want 1", gpo[1]); end
    pin[1] = 1'b0;
    step(3);
    checks++;
    if (gpo[1] !== 1'b0) begin errors++; $display("FAIL thr0_fall got %b want 0", gpo[1]); end
    wr(32'h00, 32'd100);
    wr(32'h04, 32'h80);
    pin = 8'h82;
    step(2);
    checks++;
    if (gpo !== 8'h00) begin errors++; $display("FAIL byp_early got %h want 00", gpo); end
    step(1);
    checks++;
    if (gpo !== 8'h80) begin errors++; $display("FAIL byp_edge got %h want 80", gpo); end
    step(20);
    checks++;
    if (gpo !== 8'h80) begin errors++; $display("FAIL byp_others_filtered got %h want 80", gpo); end
    pin = 8'h00;
    step(3);
    checks++;
    if (gpo !== 8'h00) begin errors++; $display("FAIL byp_fall got %h want 00", gpo); end
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'hFF);
  endtask
  task automatic test_set_clear;
    wr(32'h00, 32'd1);
    pin[2] = 1'b1;
    step(3);
    checks++;
    if (gpo[2] !== 1'b1) begin errors++; $display("FAIL sc_rise got %b want 1", gpo[2]); end
    pin[2] = 1'b0;
    step(2);
    wr(32'h0C, 32'h4);
    checks++;
    if (gpo[2] !== 1'b0) begin errors++; $display("FAIL sc_fall got %b want 0", gpo[2]); end
    rdr(32'h0C, d); checks++;
    if (d !== (IRQ_ON ? 32'h4 : 32'h0)) begin errors++; $display("FAIL sc_set_wins got %h want %h", d, IRQ_ON ? 32'h4 : 32'h0); end
    wr(32'h0C, 32'h4);
    rdr(32'h0C, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL sc_clear got %h want 0", d); end
  endtask
  task automatic test_midcount;
    wr(32'h00, 32'd50);
    pin[5] = 1'b1;
    step(12);
    wr(32'h00, 32'd2);
    checks++;
    if (gpo[5] !== 1'b0) begin errors++; $display("FAIL mid_write_edge got %b want 0", gpo[5]); end
    step(1);
    checks++;
    if (gpo[5] !== 1'b1) begin errors++; $display("FAIL mid_update got %b want 1", gpo[5]); end
    pin[5] = 1'b0;
    step(3);
    checks++;
    if (gpo[5] !== 1'b1) begin errors++; $display("FAIL mid_fall_early got %b want 1", gpo[5]); end
    step(1);
    checks++;
    if (gpo[5] !== 1'b0) begin errors++; $display("FAIL mid_fall got %b want 0", gpo[5]); end
    checks++;
    if (irq !== IRQ_ON) begin errors++; $display("FAIL mid_irq got %b want %b", irq, IRQ_ON); end
  endtask
  initial begin
    #1;
    test_reset;
    test_clean_edge;
    test_glitch;
    test_thr0_bypass;
    test_set_clear;
    test_midcount;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
